equihash_sol_txbuf: RTL and testbench

EQUIHASH_SOL_TXBUF -- requirements
Module: equihash_sol_txbuf

---
 rtl/equihash_sol_txbuf.sv | 137 +++++++++++++
 tb/tb_equihash_sol_txbuf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/equihash_sol_txbuf.sv
// Solution transmit buffer: queues 64-bit Equihash solution words and serializes them
// little-endian onto a byte-wide UART handshake, with a sync byte ahead of each new frame.
module equihash_sol_txbuf #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                       eclk,
    input  logic                       rstb,
    input  logic                       uart_start,
    input  logic [63:0]                uart_tdata,
    input  logic                       uart_headernonce_send,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    logic [63:0]   shreg;
    logic [2:0]    byte_idx;
    logic          pending_mark;

    logic          pop;
    logic          full;
    logic          push;
    logic          mark;
    logic [64:0]   head;

    // A pop only happens from IDLE, so a full FIFO can still take a push in that cycle.
    assign pop   = (state == IDLE) && (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign push  = uart_start && (!full || pop);
    assign mark  = pending_mark || uart_headernonce_send;
    assign head  = mem[rd_ptr];

    assign fifo_count = count;
    assign busy       = (count != '0) || (state != IDLE);

    always_ff @(posedge eclk) begin
        if (push) begin
            mem[wr_ptr] <= {mark, uart_tdata};
        end
    end

    always_ff @(posedge eclk or posedge rstb) begin
        if (rstb) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending_mark <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A dropped push leaves the frame marker armed for the next accepted word.
            if (push) begin
                pending_mark <= 1'b0;
            end else if (uart_headernonce_send && !uart_start) begin
                pending_mark <= 1'b1;
            end
            if (uart_start && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge eclk or posedge rstb) begin
        if (rstb) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= head[63:0];
                        byte_idx <= '0;
                        tx_valid <= 1'b1;
                        if (head[64]) begin
                            state   <= SYNC;
                            tx_data <= SYNC_BYTE;
                        end else begin
                            state   <= DATA;
                            tx_data <= head[7:0];
                        end
                    end
                end
                SYNC: begin
                    if (tx_ready) begin
                        state   <= DATA;
                        tx_data <= shreg[7:0];
                    end
                end
                DATA: begin
                    // shreg[7:0] always holds the byte currently presented on tx_data.
                    if (tx_ready) begin
                        if (byte_idx == 3'd7) begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            shreg    <= shreg >> 8;
                            tx_data  <= shreg[15:8];
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equihash_sol_txbuf.sv
// Directed self-checking bench for equihash_sol_txbuf: framing, latency, overflow,
// full-FIFO push/pop, stall stability, inter-word bubble and mid-frame reset.
module tb_equihash_sol_txbuf;

    logic        eclk = 1'b0;
    logic        rstb;
    logic        uart_start;
    logic [63:0] uart_tdata;
    logic        uart_headernonce_send;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        overflow;

    int tests = 0;
    int failures = 0;

    logic [7:0]  rx[$];
    int          xfer_cyc[$];
    bit          vlog[$];
    logic [63:0] words[$];
    bit          prev_stall;
    logic [7:0]  prev_data;

    always #5 eclk = ~eclk;

    equihash_sol_txbuf #(.DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .eclk                  (eclk),
        .rstb                  (rstb),
        .uart_start            (uart_start),
        .uart_tdata            (uart_tdata),
        .uart_headernonce_send (uart_headernonce_send),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .fifo_count            (fifo_count),
        .busy                  (busy),
        .overflow              (overflow)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: observe the handshake mid-cycle, then move just past the rising edge.
    task automatic tick();
        @(negedge eclk);
        if (prev_stall) begin
            checkOutput("stall_stable", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, prev_data});
        end
        if (tx_valid && tx_ready) begin
            rx.push_back(tx_data);
            xfer_cyc.push_back(vlog.size());
        end
        vlog.push_back(tx_valid);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        @(posedge eclk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic [63:0] data, input logic hns);
        uart_start            = start;
        uart_tdata            = data;
        uart_headernonce_send = hns;
        tick();
        uart_start            = 1'b0;
        uart_headernonce_send = 1'b0;
    endtask

    task automatic resetDut();
        rstb = 1'b1;
        uart_start = 1'b0;
        uart_tdata = '0;
        uart_headernonce_send = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge eclk);
        @(negedge eclk);
        rstb = 1'b0;
        @(posedge eclk);
        #1;
        rx.delete();
        xfer_cyc.delete();
        vlog.delete();
        words.delete();
        prev_stall = 1'b0;
    endtask

    task automatic drain(input int nbytes, input int budget);
        for (int c = 0; c < budget && rx.size() < nbytes; c++) begin
            tick();
        end
        checkOutput("drain_count", 64'(rx.size()), 64'(nbytes));
    endtask

    initial begin
        logic [63:0] w;
        int bub;

        // Reset state
        resetDut();
        checkOutput("rst_count", 64'(fifo_count), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(tx_valid), 64'd0);
        checkOutput("rst_data", 64'(tx_data), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);

        // Frame marker (pulsed twice), latency and byte order; the second word is unmarked
        tx_ready = 1'b1;
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b0);
        vlog.delete();
        applyStimulus(1'b1, 64'h0807060504030201, 1'b0);
        applyStimulus(1'b1, 64'h1817161514131211, 1'b0);
        drain(17, 40);
        checkOutput("lat_n1", 64'(vlog[1]), 64'd0);
        checkOutput("lat_n2", 64'(vlog[2]), 64'd1);
        if (rx.size() == 17) begin
            checkOutput("sync_byte", 64'(rx[0]), 64'hA5);
            for (int i = 0; i < 8; i++) begin
                checkOutput("w1_byte", 64'(rx[1+i]), 64'(8'(i + 1)));
                checkOutput("w2_byte", 64'(rx[9+i]), 64'(8'(8'h11 + i)));
            end
        end

        // Fill with the transmitter stalled, then one push too many
        resetDut();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 64'hA000_0000_0000_0000 + 64'(i), 1'b0);
        end
        tick();
        checkOutput("full_count", 64'(fifo_count), 64'd16);
        checkOutput("full_ovf", 64'(overflow), 64'd0);
        checkOutput("full_head", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, 8'h00});
        applyStimulus(1'b1, 64'hDEAD, 1'b0);
        checkOutput("drop_ovf", 64'(overflow), 64'd1);
        checkOutput("drop_count", 64'(fifo_count), 64'd16);
        repeat (5) tick();
        checkOutput("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO: a push in the IDLE pop cycle is accepted without overflow
        resetDut();
        for (int i = 0; i < 17; i++) begin
            w = 64'h0123_4567_0000_0000 + 64'(i * 17);
            words.push_back(w);
            applyStimulus(1'b1, w, 1'b0);
        end
        tx_ready = 1'b1;
        repeat (8) tick();
        checkOutput("pp_idle_count", 64'(fifo_count), 64'd16);
        w = 64'hFEDC_BA98_7654_3210;
        words.push_back(w);
        applyStimulus(1'b1, w, 1'b0);
        checkOutput("pp_count", 64'(fifo_count), 64'd16);
        checkOutput("pp_ovf", 64'(overflow), 64'd0);
        drain(144, 400);
        if (rx.size() == 144) begin
            for (int k = 0; k < 18; k++) begin
                w = words[k];
                for (int b = 0; b < 8; b++) begin
                    checkOutput("pp_byte", 64'(rx[k*8+b]), 64'(w[b*8 +: 8]));
                end
            end
        end

        // Two unmarked words with tx_ready toggling
        resetDut();
        applyStimulus(1'b1, 64'h1122334455667788, 1'b0);
        applyStimulus(1'b1, 64'h99AABBCCDDEEFF00, 1'b0);
        for (int c = 0; c < 80 && rx.size() < 16; c++) begin
            tx_ready = c[0];
            tick();
        end
        tx_ready = 1'b0;
        checkOutput("tog_count", 64'(rx.size()), 64'd16);
        if (rx.size() == 16) begin
            w = 64'h1122334455667788;
            for (int b = 0; b < 8; b++) checkOutput("tog_w1", 64'(rx[b]), 64'(w[b*8 +: 8]));
            w = 64'h99AABBCCDDEEFF00;
            for (int b = 0; b < 8; b++) checkOutput("tog_w2", 64'(rx[8+b]), 64'(w[b*8 +: 8]));
            bub = 0;
            for (int c = xfer_cyc[7] + 1; c < xfer_cyc[8]; c++) begin
                if (!vlog[c]) bub++;
            end
            checkOutput("bubble", 64'(bub), 64'd1);
        end

        // Reset asserted mid-frame at byte index 3 with three words queued
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'h5555_0000_0000_0000 + 64'(i), 1'b0);
        end
        tx_ready = 1'b1;
        repeat (3) tick();
        checkOutput("pre_rst_count", 64'(fifo_count), 64'd3);
        rstb = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 64'(tx_valid), 64'd0);
        checkOutput("mid_rst_count", 64'(fifo_count), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        resetDut();
        tx_ready = 1'b1;
        repeat (20) tick();
        checkOutput("post_rst_rx", 64'(rx.size()), 64'd0);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, 64'h77, 1'b0);
        checkOutput("post_rst_push", 64'(fifo_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
